// File: rtl/board_eval_if.sv
// board_eval_if: Avalon-MM style bus shared by the host (slave side) and memory (master side) ports
interface board_eval_if #(parameter int AW = 32);
  logic          waitrequest;
  logic [AW-1:0] address;
  logic          read;
  logic [31:0]   readdata;
  logic          readdatavalid;
  logic          write;
  logic [31:0]   writedata;
  modport master(output address, read, write, writedata, input waitrequest, readdata, readdatavalid);
  modport slave(input address, read, write, writedata, output waitrequest, readdata);
endinterface

// File: rtl/board_eval.sv
// board_eval: scans board_count 8x8 boards through a read master and keeps the best material score
module board_eval (
  input logic           clk,
  input logic           rst_n,
  board_eval_if.slave   s,
  board_eval_if.master  m
);
  typedef enum logic [3:0] {IDLE, LATCH, ACK_START, CHECK_BOARD, RD_SQ, ACC, CMP, NEXT_BOARD, DONE} state_t;
  state_t             state_q, state_d;
  logic               done_q, done_d, max_q, max_d;
  logic [31:0]        best_idx_q, best_idx_d, base_q, base_d;
  logic signed [15:0] best_score_q, best_score_d, acc_q, acc_d;
  logic [7:0]         board_q, board_d, count_q, count_d, piece_q, piece_d;
  logic [5:0]         sq_q, sq_d;
  logic [7:0]         mag;
  logic signed [15:0] val, contrib;
  logic               better, rd_en;
  logic               unused;
  always_comb begin
    mag = piece_q[7] ? 8'(-piece_q) : piece_q;
    val = mag == 8'd1 ? 16'sd1 :
          (mag == 8'd2 || mag == 8'd3) ? 16'sd3 :
          mag == 8'd4 ? 16'sd5 :
          mag == 8'd5 ? 16'sd9 :
          mag == 8'd6 ? 16'sd100 : 16'sd0;
    contrib = piece_q[7] ? -val : val;
    // strict comparison keeps the lower index on ties; board 0 always seeds the result
    better = board_q == 8'd0 || (max_q ? acc_q > best_score_q : acc_q < best_score_q);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      best_idx_q   <= '1;
      best_score_q <= '0;
      acc_q        <= '0;
      board_q      <= '0;
      sq_q         <= '0;
      base_q       <= '1;
      count_q      <= '0;
      max_q        <= 1'b1;
      piece_q      <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      acc_q        <= acc_d;
      board_q      <= board_d;
      sq_q         <= sq_d;
      base_q       <= base_d;
      count_q      <= count_d;
      max_q        <= max_d;
      piece_q      <= piece_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    acc_d        = acc_q;
    board_d      = board_q;
    sq_d         = sq_q;
    base_d       = base_q;
    count_d      = count_q;
    max_d        = max_q;
    piece_d      = piece_q;
    case (state_q)
      IDLE: if (s.write) begin
        state_d = s.address == 4'd0 ? ACK_START : LATCH;
        base_d  = s.address == 4'd1 ? s.writedata : base_q;
        count_d = s.address == 4'd2 ? s.writedata[7:0] : count_q;
        max_d   = s.address == 4'd3 ? s.writedata[0] : max_q;
      end
      LATCH: state_d = IDLE;
      ACK_START: begin
        state_d      = CHECK_BOARD;
        board_d      = '0;
        sq_d         = '0;
        done_d       = 1'b0;
        best_idx_d   = '1;
        best_score_d = '0;
      end
      CHECK_BOARD: begin
        state_d = board_q == count_q ? DONE : RD_SQ;
        done_d  = board_q == count_q;
        acc_d   = board_q == count_q ? acc_q : 16'sd0;
      end
      RD_SQ: if (m.readdatavalid) begin
        state_d = ACC;
        piece_d = m.readdata[7:0];
      end
      ACC: begin
        acc_d   = acc_q + contrib;
        state_d = sq_q == 6'd63 ? CMP : RD_SQ;
        sq_d    = sq_q + 6'd1;
      end
      CMP: begin
        state_d      = NEXT_BOARD;
        best_idx_d   = better ? {24'd0, board_q} : best_idx_q;
        best_score_d = better ? acc_q : best_score_q;
      end
      NEXT_BOARD: begin
        board_d = board_q + 8'd1;
        sq_d    = '0;
        state_d = CHECK_BOARD;
      end
      DONE: state_d = (s.read && s.address == 4'd0) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // outputs are gated by rst_n so they sit at their idle values while reset is held
  assign rd_en         = rst_n && state_q == RD_SQ;
  assign s.waitrequest = rst_n && !(state_q inside {IDLE, ACK_START, DONE});
  assign s.readdata    = s.address == 4'd0 ? {31'd0, done_q} :
                         s.address == 4'd1 ? best_idx_q :
                         s.address == 4'd2 ? {{16{best_score_q[15]}}, best_score_q} : 32'd0;
  assign m.read        = rd_en;
  assign m.address     = rd_en ? base_q + {18'd0, board_q, sq_q} : '1;
  assign m.write       = 1'b0;
  assign m.writedata   = '0;
  assign unused        = ^{m.waitrequest, m.readdata[31:8]};
endmodule

// File: tb/tb_board_eval.sv
// tb_board_eval: directed scoreboard bench for board_eval with a latency-randomising memory model
module tb_board_eval;
  logic clk = 0, rst_n = 0, rnd = 0;
  int tests = 0, fails = 0, addr_errs = 0;
  logic [31:0] exp_q[$];
  string name_q[$];
  logic [7:0] mem[logic [31:0]];
  board_eval_if hs();
  board_eval_if mm();
  board_eval dut(.clk(clk), .rst_n(rst_n), .s(hs), .m(mm));
  always #5 clk = ~clk;

  function automatic void chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, got, exp);
    end
  endfunction

  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'd0;
  endfunction

  // kinds: 0 empty, 1 start position, 2 start+white queen, 3 start+black rook, 4 knight, 5 bishop, 6 mixed wrap
  function automatic void board(input logic [31:0] base, input int i, input int kind);
    logic [31:0] b;
    logic [7:0] back[8];
    logic [7:0] pcs[15];
    b = base + 32'(64 * i);
    back = '{8'd4, 8'd2, 8'd3, 8'd5, 8'd6, 8'd3, 8'd2, 8'd4};
    pcs = '{8'd6, 8'hFA, 8'd1, 8'hFF, 8'd7, 8'h80, 8'hFE, 8'd5, 8'hFB, 8'd2, 8'hFD, 8'd3, 8'd4, 8'hFC, 8'd1};
    if (kind >= 1 && kind <= 3)
      for (int x = 0; x < 8; x++) begin
        mem[b + 32'(x)] = back[x];
        mem[b + 32'(8 + x)] = 8'd1;
        mem[b + 32'(48 + x)] = 8'hFF;
        mem[b + 32'(56 + x)] = 8'(-back[x]);
      end
    if (kind == 2) mem[b + 32'd27] = 8'd5;
    if (kind == 3) mem[b + 32'd35] = 8'hFC;
    if (kind == 4) mem[b + 32'd20] = 8'd2;
    if (kind == 5) mem[b + 32'd40] = 8'd3;
    if (kind == 6)
      for (int k = 0; k < 15; k++) mem[b + 32'(30 + k)] = pcs[k];
  endfunction

  task automatic host_wr(input logic [3:0] a, input logic [31:0] d);
    int k = 0;
    hs.address = a; hs.writedata = d; hs.write = 1;
    @(negedge clk);
    while (hs.waitrequest && k < 20000) begin @(negedge clk); k++; end
    if (k == 20000) begin tests++; fails++; $display("FAIL wr_timeout addr %0d", a); end
    @(posedge clk); #1 hs.write = 0;
  endtask

  task automatic host_rd(input logic [3:0] a, input logic [31:0] e, input string n);
    int k = 0;
    exp_q.push_back(e); name_q.push_back(n);
    hs.address = a; hs.read = 1;
    @(negedge clk);
    while (hs.waitrequest && k < 20000) begin @(negedge clk); k++; end
    if (k == 20000) begin
      void'(exp_q.pop_back()); void'(name_q.pop_back());
      tests++; fails++; $display("FAIL %s: read timeout", n);
    end
    @(posedge clk); #1 hs.read = 0;
  endtask

  task automatic run(input string t, input logic [31:0] base, input logic [7:0] cnt, input bit mx,
                     input logic [31:0] ei, input logic [15:0] es, input int lat);
    int k = 0;
    addr_errs = 0;
    host_wr(4'd1, base); host_wr(4'd2, {24'd0, cnt}); host_wr(4'd3, {31'd0, mx}); host_wr(4'd0, 32'd0);
    @(negedge clk);
    do begin @(negedge clk); k++; end while (hs.waitrequest && k < 20000);
    if (lat >= 0) chk({t, ".latency"}, k, lat);
    else if (k == 20000) begin tests++; fails++; $display("FAIL %s.busy: timeout", t); end
    @(posedge clk); #1;
    host_rd(4'd0, 32'd1, {t, ".done"});
    host_rd(4'd1, ei, {t, ".best_index"});
    host_rd(4'd2, {{16{es[15]}}, es}, {t, ".best_score"});
    chk({t, ".addr_stable_errs"}, addr_errs, 0);
    chk({t, ".master_write"}, {31'd0, mm.write}, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && hs.read && !hs.waitrequest) begin
      if (exp_q.size() == 0) begin tests++; fails++; $display("FAIL unexpected_read: got 0x%08h", hs.readdata); end
      else chk(name_q.pop_front(), hs.readdata, exp_q.pop_front());
    end
  end

  // memory: answers each read after 0..5 cycles (0 when rnd is clear) and checks address stability
  initial begin
    int cnt = 0, dly = 0;
    logic [31:0] a = 0;
    mm.readdatavalid = 0; mm.readdata = 0; mm.waitrequest = 0;
    forever begin
      @(negedge clk);
      mm.readdatavalid = 0;
      if (rst_n && mm.read) begin
        if (cnt == 0) begin a = mm.address; dly = rnd ? int'($urandom_range(0, 5)) : 0; end
        else if (mm.address != a) addr_errs++;
        if (cnt >= dly) begin mm.readdatavalid = 1; mm.readdata = {24'hA5C3E1, rd(a)}; cnt = 0; end
        else cnt++;
      end else cnt = 0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    int k = 0;
    hs.address = 0; hs.read = 0; hs.write = 0; hs.writedata = 0; hs.readdatavalid = 0;
    board(32'h100, 0, 1);
    board(32'h2000, 0, 2); board(32'h2000, 1, 0); board(32'h2000, 2, 3);
    board(32'h3000, 0, 4); board(32'h3000, 1, 5);
    board(32'hFFFFFFE0, 0, 6); board(32'hFFFFFFE0, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.waitrequest", {31'd0, hs.waitrequest}, 0);
    chk("rst.master_read", {31'd0, mm.read}, 0);
    chk("rst.master_write", {31'd0, mm.write}, 0);
    chk("rst.master_address", mm.address, 32'hFFFFFFFF);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    host_rd(4'd0, 32'd0, "rst.done");
    host_rd(4'd1, 32'hFFFFFFFF, "rst.best_index");
    host_rd(4'd2, 32'd0, "rst.best_score");
    host_rd(4'd7, 32'd0, "rst.unmapped");
    run("init1", 32'h100, 8'd1, 1'b1, 32'd0, 16'd0, 133);
    run("max3", 32'h2000, 8'd3, 1'b1, 32'd0, 16'd9, 395);
    run("min3", 32'h2000, 8'd3, 1'b0, 32'd2, -16'sd5, 395);
    run("tie_max", 32'h3000, 8'd2, 1'b1, 32'd0, 16'd3, -1);
    run("tie_min", 32'h3000, 8'd2, 1'b0, 32'd0, 16'd3, -1);
    run("wrap_max", 32'hFFFFFFE0, 8'd2, 1'b1, 32'd0, 16'd1, -1);
    run("wrap_min", 32'hFFFFFFE0, 8'd2, 1'b0, 32'd1, 16'd0, -1);
    run("zero", 32'h100, 8'd0, 1'b1, 32'hFFFFFFFF, 16'd0, 2);
    rnd = 1;
    run("rnd_max3", 32'h2000, 8'd3, 1'b1, 32'd0, 16'd9, -1);
    run("rnd_min3", 32'h2000, 8'd3, 1'b0, 32'd2, -16'sd5, -1);
    run("rnd_init1", 32'h100, 8'd1, 1'b0, 32'd0, 16'd0, -1);
    rnd = 0;
    host_wr(4'd1, 32'h2000); host_wr(4'd2, 32'd3); host_wr(4'd3, 32'd1); host_wr(4'd0, 32'd0);
    do begin @(negedge clk); k++; end while (!(mm.read && mm.address == 32'h205E) && k < 5000);
    if (k == 5000) begin tests++; fails++; $display("FAIL midrst.reach_square30: timeout"); end
    rst_n = 0;
    @(posedge clk); #1;
    chk("midrst.during.waitrequest", {31'd0, hs.waitrequest}, 0);
    chk("midrst.during.master_read", {31'd0, mm.read}, 0);
    chk("midrst.during.master_address", mm.address, 32'hFFFFFFFF);
    rst_n = 1;
    @(negedge clk);
    chk("midrst.after.master_read", {31'd0, mm.read}, 0);
    chk("midrst.after.idle_waitrequest", {31'd0, hs.waitrequest}, 0);
    @(posedge clk); #1;
    host_rd(4'd0, 32'd0, "midrst.done");
    host_rd(4'd1, 32'hFFFFFFFF, "midrst.best_index");
    host_rd(4'd2, 32'd0, "midrst.best_score");
    run("restart", 32'h2000, 8'd3, 1'b1, 32'd0, 16'd9, 395);
    if (exp_q.size() != 0) begin tests++; fails++; $display("FAIL scoreboard_leftover: %0d entries", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
